// File: rtl/gt_line_responder.sv
// Cache line-fill responder: answers read requests after LATENCY cycles from a
// 16-entry writeback line store, falling back to an address-derived byte pattern.
module gt_line_responder #(
    parameter int unsigned LATENCY = 4
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    input  logic         wb_valid,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_addr,
    output logic [255:0] rsp_data,
    output logic [15:0]  rd_count
);
    localparam int unsigned LINE_ADDR_W = 27;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned TAG_W       = LINE_ADDR_W - IDX_W;
    localparam int unsigned LINE_W      = 256;
    localparam int unsigned LINE_BYTES  = LINE_W / 8;
    localparam int unsigned DEPTH       = 1 << IDX_W;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } lineT;

    stateT              state;
    stateT              nextState;
    logic               accept;
    logic               fill;
    logic               retire;
    logic [31:0]        reqAddr;
    logic [CNT_W-1:0]   cnt;
    logic [DEPTH-1:0]   lineValid;
    lineT               lineMem [DEPTH];
    logic [IDX_W-1:0]   reqIdx;
    logic [IDX_W-1:0]   wbIdx;
    logic               hit;
    logic               fwd;
    logic [LINE_W-1:0]  fillData;
    logic               unusedWbHi;

    // Byte k of a missing line is the low byte of (line byte address + k).
    function automatic logic [LINE_W-1:0] linePattern(input logic [LINE_ADDR_W-1:0] a);
        logic [LINE_W-1:0] p;
        logic [31:0]       base;
        base = {a, 5'b0};
        for (int k = 0; k < int'(LINE_BYTES); k++) begin
            p[8*k +: 8] = 8'(base + 32'(k));
        end
        return p;
    endfunction

    assign req_ready  = (state == IDLE);
    assign unusedWbHi = ^wb_addr[31:LINE_ADDR_W];

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        fill      = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    fill      = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    retire    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A writeback to the requested line on the fill edge wins over the store.
    assign reqIdx = reqAddr[IDX_W-1:0];
    assign wbIdx  = wb_addr[IDX_W-1:0];
    assign hit    = lineValid[reqIdx] && (lineMem[reqIdx].tag == reqAddr[LINE_ADDR_W-1:IDX_W]);
    assign fwd    = wb_valid && (wb_addr[LINE_ADDR_W-1:0] == reqAddr[LINE_ADDR_W-1:0]);

    always_comb begin
        fillData = linePattern(reqAddr[LINE_ADDR_W-1:0]);
        if (fwd) begin
            fillData = wb_data;
        end else if (hit) begin
            fillData = lineMem[reqIdx].data;
        end
    end

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            reqAddr   <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rd_count  <= '0;
            lineValid <= '0;
        end else begin
            if (accept) begin
                reqAddr <= req_addr;
                cnt     <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (fill) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= reqAddr;
                rsp_data  <= fillData;
            end
            if (retire) begin
                rsp_valid <= 1'b0;
                if (rd_count != '1) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
            if (wb_valid) begin
                lineValid[wbIdx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset; validity bits gate their use.
    always_ff @(posedge CLK) begin
        if (wb_valid && !CLEAR) begin
            lineMem[wbIdx] <= '{tag: wb_addr[LINE_ADDR_W-1:IDX_W], data: wb_data};
        end
    end

endmodule

// File: tb/tb_gt_line_responder.sv
// Scoreboard bench for gt_line_responder: LATENCY=4 instance for function,
// LATENCY=1 instance for back-to-back throughput.
module tb_gt_line_responder;
    localparam int unsigned LAT = 4;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
        int           acc;
    } expT;

    logic         CLK = 1'b0;
    logic         CLEAR;
    logic         req_valid, req_ready, wb_valid, rsp_valid, rsp_ready;
    logic [31:0]  req_addr, wb_addr, rsp_addr;
    logic [255:0] wb_data, rsp_data;
    logic [15:0]  rd_count;

    logic         req_valid1, req_ready1, wb_valid1, rsp_valid1, rsp_ready1;
    logic [31:0]  req_addr1, wb_addr1, rsp_addr1;
    logic [255:0] wb_data1, rsp_data1;
    logic [15:0]  rd_count1;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  expRd = 0;
    int  nextRise1 = 0;
    int  rises1 = 0;
    bit  prevValid = 1'b0;
    bit  prevValid1 = 1'b0;
    expT sb[$];
    expT cur;

    gt_line_responder #(.LATENCY(LAT)) dut (
        .CLK(CLK), .CLEAR(CLEAR),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rd_count(rd_count)
    );

    gt_line_responder #(.LATENCY(1)) dut1 (
        .CLK(CLK), .CLEAR(CLEAR),
        .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .wb_valid(wb_valid1), .wb_addr(wb_addr1), .wb_data(wb_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_addr(rsp_addr1),
        .rsp_data(rsp_data1), .rd_count(rd_count1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] p;
        for (int k = 0; k < 32; k++) p[8*k +: 8] = {a[2:0], 5'(k)};
        return p;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        check(name, 256'(act), 256'(want));
    endtask

    // Monitor: pops the scoreboard on every response rise, then checks hold stability.
    always @(negedge CLK) begin
        if (rsp_valid) begin
            if (!prevValid) begin
                if (sb.size() == 0) begin
                    chk32("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk32("rsp_latency", 32'(cyc), 32'(cur.acc + int'(LAT)));
                    chk32("rsp_addr", rsp_addr, cur.addr);
                    check("rsp_data", rsp_data, cur.data);
                end
            end else begin
                chk32("hold_addr", rsp_addr, cur.addr);
                check("hold_data", rsp_data, cur.data);
            end
        end
        prevValid = rsp_valid;
        if (rsp_valid1 && !prevValid1) begin
            chk32("l1_rise_cycle", 32'(cyc), 32'(nextRise1));
            chk32("l1_addr", rsp_addr1, 32'h3);
            check("l1_data", rsp_data1, pat(32'h3));
            nextRise1 = nextRise1 + 3;
            rises1++;
        end
        prevValid1 = rsp_valid1;
    end

    task automatic issueReq(input logic [31:0] a, input logic [255:0] d);
        int  n = 0;
        expT e;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            chk32("req_ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            e.addr = a;
            e.data = d;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic doWb(input logic [31:0] a, input logic [255:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        @(negedge CLK);
        wb_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk32("drain_timeout", 32'(n < 60), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CLEAR = 1'b1;
        req_valid = 1'b0; req_addr = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0; wb_valid1 = 1'b0; wb_addr1 = '0; wb_data1 = '0;
        rsp_ready1 = 1'b1;
        repeat (2) @(negedge CLK);
        chk32("rst_req_ready", 32'(req_ready), 32'd1);
        chk32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk32("rst_rsp_addr", rsp_addr, 32'd0);
        check("rst_rsp_data", rsp_data, 256'd0);
        chk32("rst_rd_count", 32'(rd_count), 32'd0);
        CLEAR = 1'b0;

        // Pattern reads, including ignored high address bits.
        issueReq(32'h0000_0002, pat(32'h2));
        waitDone();
        expRd++;
        chk32("rd_count_1", 32'(rd_count), 32'(expRd));
        issueReq(32'hF800_0002, pat(32'h2));
        waitDone();
        expRd++;

        // Store hit and same-index tag miss.
        doWb(32'h15, {32{8'hA5}});
        issueReq(32'h15, {32{8'hA5}});
        waitDone();
        issueReq(32'h25, pat(32'h25));
        waitDone();
        expRd += 2;
        chk32("rd_count_4", 32'(rd_count), 32'(expRd));

        // Writeback on the fill edge, then during WAIT over stale store data.
        issueReq(32'h7, {32{8'h3C}});
        repeat (3) @(negedge CLK);
        doWb(32'h7, {32{8'h3C}});
        waitDone();
        doWb(32'h7, {32{8'h5A}});
        issueReq(32'h7, {32{8'h3C}});
        @(negedge CLK);
        doWb(32'h7, {32{8'h3C}});
        waitDone();
        expRd += 2;

        // Back-pressure: held response, ignored request, writeback in RESP.
        rsp_ready = 1'b0;
        issueReq(32'h31, pat(32'h31));
        begin
            int n = 0;
            while (!rsp_valid && n < 40) begin
                @(negedge CLK);
                n++;
            end
        end
        chk32("hold_rsp_seen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk32("hold_req_ready", 32'(req_ready), 32'd0);
            chk32("hold_valid", 32'(rsp_valid), 32'd1);
            chk32("hold_rd_count", 32'(rd_count), 32'(expRd));
            req_valid = 1'b1;
            req_addr  = 32'h99;
            if (i == 0) begin
                wb_valid = 1'b1; wb_addr = 32'h31; wb_data = {32{8'hFF}};
            end
            @(negedge CLK);
            wb_valid = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        waitDone();
        expRd++;
        chk32("rd_count_after_hold", 32'(rd_count), 32'(expRd));

        // CLEAR mid-WAIT abandons the read and drops store contents.
        doWb(32'h44, {32{8'h77}});
        issueReq(32'h44, {32{8'h77}});
        waitDone();
        issueReq(32'h44, {32{8'h77}});
        @(negedge CLK);
        #2;
        CLEAR = 1'b1;
        wb_valid = 1'b1; wb_addr = 32'h44; wb_data = {32{8'h77}};
        #1;
        chk32("clr_req_ready", 32'(req_ready), 32'd1);
        chk32("clr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk32("clr_rd_count", 32'(rd_count), 32'd0);
        chk32("clr_rsp_addr", rsp_addr, 32'd0);
        check("clr_rsp_data", rsp_data, 256'd0);
        sb.delete();
        expRd = 0;
        @(negedge CLK);
        wb_valid = 1'b0;
        CLEAR = 1'b0;
        issueReq(32'h44, pat(32'h44));
        waitDone();
        expRd++;
        chk32("rd_count_after_clr", 32'(rd_count), 32'(expRd));

        // LATENCY=1 instance with a request held continuously.
        req_valid1 = 1'b1;
        req_addr1  = 32'h3;
        nextRise1  = cyc + 2;
        repeat (10) @(negedge CLK);
        req_valid1 = 1'b0;
        repeat (4) @(negedge CLK);
        chk32("l1_rises", 32'(rises1), 32'd4);
        chk32("l1_rd_count", 32'(rd_count1), 32'd4);
        chk32("l1_req_ready", 32'(req_ready1), 32'd1);

        repeat (4) @(negedge CLK);
        chk32("sb_empty", 32'(sb.size()), 32'd0);
        chk32("rd_count_final", 32'(rd_count), 32'(expRd));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gt_line_responder.md
GT_LINE_RESPONDER -- requirements
Module: GT_line_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from read-request acceptance to rsp_valid; legal range 1..15.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on posedge CLK.
REQ-003 SHALL have port CLEAR  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  cache line-fill request present.
REQ-005 SHALL have port req_addr  input  32  line address, byte address >> 5; only bits [26:0] significant.
REQ-006 SHALL have port req_ready  output  1  responder can accept a read request.
REQ-007 SHALL have port wb_valid  input  1  victim writeback present; always accepted.
REQ-008 SHALL have port wb_addr  input  32  writeback line address, same format as req_addr.
REQ-009 SHALL have port wb_data  input  256  evicted line; byte k = wb_data[8k+7:8k].
REQ-010 SHALL have port rsp_valid  output  1  rsp_data/rsp_addr valid.
REQ-011 SHALL have port rsp_ready  input  1  cache consumes the response.
REQ-012 SHALL have port rsp_addr  output  32  line address of the response.
REQ-013 SHALL have port rsp_data  output  256  returned line.
REQ-014 SHALL have port rd_count  output  16  completed read responses, saturating.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a read when req_valid & req_ready at a posedge: capture req_addr, load counter with LATENCY-1, enter WAIT.
REQ-017 SHALL decrement the counter each cycle in WAIT; on the posedge where it is 0, latch rsp_data and enter RESP.
REQ-018 SHALL assert rsp_valid exactly LATENCY cycles after the accepting posedge (LATENCY=1: next cycle).
REQ-019 SHALL hold rsp_valid, rsp_addr, rsp_data stable in RESP until rsp_ready = 1; the posedge with rsp_ready = 1 returns to IDLE and increments rd_count.
REQ-020 SHALL saturate rd_count at 16'hFFFF.
REQ-021 SHALL store writebacks in a 16-entry line store indexed by addr[3:0], each entry holding a valid bit, 23-bit tag addr[26:4] and 256-bit data.
REQ-022 SHALL on wb_valid write the entry unconditionally (set valid, overwrite tag and data) in any FSM state.
REQ-023 SHALL source read data as: entry valid with tag match -> stored data; otherwise generated pattern, byte k = ((addr[26:0] << 5) + k)[7:0].
REQ-024 SHALL forward wb_data into rsp_data when wb_valid with the same line address occurs on the latching posedge (write wins).
REQ-025 SHALL make a writeback during WAIT to the requested line visible in the response; writebacks in RESP do not alter held rsp_data.
REQ-026 SHALL ignore req_valid outside IDLE; the requester holds the request until req_ready.
REQ-027 SHALL ignore address bits [31:27] for storage, tag compare and pattern, but return them unchanged in rsp_addr.

Reset
REQ-028 SHALL on CLEAR = 1, immediately and independent of CLK: FSM to IDLE, req_ready = 1, rsp_valid = 0, rsp_addr = 0, rsp_data = 0, rd_count = 0, counter = 0, all entry valid bits = 0.
REQ-029 SHALL abandon any in-flight read on CLEAR mid-operation with no response produced; a wb_valid on a posedge while CLEAR = 1 is dropped.
REQ-030 SHALL accept a new request on the first posedge after CLEAR deasserts.

Verification
REQ-031 SHALL pass: reset, req_addr = 32'h0000_0002 at cycle 0, rsp_ready = 1 -> rsp_valid at cycle 4, rsp_data byte0 = 8'h40, byte31 = 8'h5F, rd_count = 1.
REQ-032 SHALL pass: wb_addr = 32'h15, wb_data = {32{8'hA5}}, then read 32'h15 -> rsp_data = {32{8'hA5}}; read 32'h25 (same index, different tag) -> pattern byte0 = 8'hA0.
REQ-033 SHALL pass: read 32'h7 accepted, wb to 32'h7 with {32{8'h3C}} two cycles later -> response {32{8'h3C}}; same wb on the latching posedge -> {32{8'h3C}}.
REQ-034 SHALL pass: rsp_ready held 0 for 6 cycles -> rsp_valid and data stable, req_ready = 0 throughout, new req_valid ignored; rd_count increments once.
REQ-035 SHALL pass: CLEAR pulsed during WAIT -> rsp_valid never asserts, req_ready = 1 asynchronously, earlier writeback data no longer returned (pattern instead).
REQ-036 SHALL pass: LATENCY = 1 build, back-to-back requests with rsp_ready = 1 -> one response every 3 cycles, rsp_valid one cycle after each accept.
